scale_pipe: RTL and testbench

SCALE_PIPE -- requirements
Module: scale_pipe

---
 rtl/scale_pkg.sv | 19 +
 rtl/pixel_delay.sv | 39 +++
 rtl/scale_pipe.sv | 185 ++++++++++++++++++
 tb/tb_scale_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// Shared types and constants for the scale_pipe integer pixel scaler.
package scale_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef enum logic [1:0] {
    SCALE_1X = 2'd0,
    SCALE_2X = 2'd1,
    SCALE_3X = 2'd2,
    SCALE_4X = 2'd3
  } scale_e;

  // Input-to-output latency: address register, rd_lat read cycles, output register.
  function automatic int LAT(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/pixel_delay.sv
// Fixed-depth shift register with synchronous flush; aligns raster side-band
// information with frame-buffer read data.
module pixel_delay
  import scale_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [WIDTH-1:0] stage_q [DEPTH];

  // Next contents of every stage.
  always_comb begin
    stage_d[0] = data_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers, flushed by reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign data_out = stage_q[DEPTH-1];

endmodule

// File: rtl/scale_pipe.sv
// Integer 1x..4x nearest-neighbour scaler: turns the raster position into frame-buffer
// read addresses and aligns returned pixels. Build macro SCALE_BORDER_EN paints the outer source ring.
module scale_pipe
  import scale_pkg::*;
#(
  parameter int               SRC_W        = 240,
  parameter int               SRC_H        = 320,
  parameter int               PIX_W        = 16,
  parameter int               RD_LAT       = 2,
  parameter logic [PIX_W-1:0] BORDER_COLOR = 16'hFFFF,
  localparam int              ADDR_W       = $clog2(SRC_W * SRC_H)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [1:0]          scale_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  output logic [ADDR_W-1:0]   addr_out,
  input  logic [PIX_W-1:0]    frame_buff_in,
  output logic [PIX_W-1:0]    pixel_out,
  output logic                valid_out,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out
);

  localparam int                SX_W     = $clog2(SRC_W + 1);
  localparam int                SY_W     = $clog2(SRC_H + 1);
  localparam logic [SX_W-1:0]   SX_END   = SX_W'(SRC_W);
  localparam logic [SY_W-1:0]   SY_END   = SY_W'(SRC_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);
  localparam int                PIPE_LAT = LAT(RD_LAT);
`ifdef SCALE_BORDER_EN
  localparam logic [SX_W-1:0]   SX_LAST  = SX_W'(SRC_W - 1);
  localparam logic [SY_W-1:0]   SY_LAST  = SY_W'(SRC_H - 1);
  localparam int                TAG_W    = 2 + HCOUNT_W + VCOUNT_W;
`else
  localparam int                TAG_W    = 1 + HCOUNT_W + VCOUNT_W;
`endif

  scale_e              scale_q, scale_d;
  logic                est_q, est_d;
  logic [1:0]          x_rep_q, x_rep_d, y_rep_q, y_rep_d;
  logic [SX_W-1:0]     src_x_q, src_x_d;
  logic [SY_W-1:0]     src_y_q, src_y_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d, addr_q, addr_d;
  logic [PIX_W-1:0]    pixel_q, pixel_d;
  logic                valid_q, valid_d, win_dly_s;
  logic [HCOUNT_W-1:0] hcount_q, hcount_d;
  logic [VCOUNT_W-1:0] vcount_q, vcount_d;
  logic                line_start_s, frame_start_s, in_win_s;
  logic [TAG_W-1:0]    tag_in_s, tag_out_s;

  assign line_start_s  = (hcount_in == '0);
  assign frame_start_s = line_start_s && (vcount_in == '0);

  // Raster-to-source counters; *_d is the source position of the current input cycle.
  always_comb begin
    scale_d    = scale_q;
    est_d      = est_q;
    x_rep_d    = x_rep_q;
    src_x_d    = src_x_q;
    y_rep_d    = y_rep_q;
    src_y_d    = src_y_q;
    row_base_d = row_base_q;
    if (frame_start_s) begin
      scale_d    = scale_e'(scale_in);
      est_d      = 1'b1;
      x_rep_d    = 2'd0;
      src_x_d    = '0;
      y_rep_d    = 2'd0;
      src_y_d    = '0;
      row_base_d = '0;
    end else if (line_start_s) begin
      x_rep_d = 2'd0;
      src_x_d = '0;
      if (y_rep_q == scale_q) begin
        y_rep_d = 2'd0;
        if (src_y_q != SY_END) begin
          src_y_d    = src_y_q + SY_W'(1);
          row_base_d = row_base_q + ROW_STEP;
        end else begin
          src_y_d    = src_y_q;
          row_base_d = row_base_q;
        end
      end else begin
        y_rep_d = y_rep_q + 2'd1;
      end
    end else begin
      if (x_rep_q == scale_q) begin
        x_rep_d = 2'd0;
        if (src_x_q != SX_END) begin
          src_x_d = src_x_q + SX_W'(1);
        end else begin
          src_x_d = src_x_q;
        end
      end else begin
        x_rep_d = x_rep_q + 2'd1;
      end
    end
  end

  // est_d gates the window so a mid-frame reset stays dark until the next frame start.
  assign in_win_s = est_d && (src_x_d < SX_END) && (src_y_d < SY_END);
  assign addr_d   = in_win_s ? (row_base_d + ADDR_W'(src_x_d)) : '0;

`ifdef SCALE_BORDER_EN
  logic border_s;
  assign border_s = (src_x_d == '0) || (src_x_d == SX_LAST) ||
                    (src_y_d == '0) || (src_y_d == SY_LAST);
  assign tag_in_s = {in_win_s, border_s, hcount_in, vcount_in};
`else
  assign tag_in_s = {in_win_s, hcount_in, vcount_in};
`endif

  pixel_delay #(
    .WIDTH (TAG_W),
    .DEPTH (PIPE_LAT - 1)
  ) u_pixel_delay (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (tag_in_s),
    .data_out (tag_out_s)
  );

  // Output stage: select read data, border colour or black.
  always_comb begin
    win_dly_s = tag_out_s[TAG_W-1];
    valid_d   = win_dly_s;
    hcount_d  = tag_out_s[VCOUNT_W +: HCOUNT_W];
    vcount_d  = tag_out_s[VCOUNT_W-1:0];
`ifdef SCALE_BORDER_EN
    if (!win_dly_s) begin
      pixel_d = '0;
    end else if (tag_out_s[TAG_W-2]) begin
      pixel_d = BORDER_COLOR;
    end else begin
      pixel_d = frame_buff_in;
    end
`else
    if (win_dly_s) begin
      pixel_d = frame_buff_in;
    end else begin
      pixel_d = '0;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      scale_q    <= SCALE_1X;
      est_q      <= 1'b0;
      x_rep_q    <= 2'd0;
      src_x_q    <= '0;
      y_rep_q    <= 2'd0;
      src_y_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      pixel_q    <= '0;
      valid_q    <= 1'b0;
      hcount_q   <= '0;
      vcount_q   <= '0;
    end else begin
      scale_q    <= scale_d;
      est_q      <= est_d;
      x_rep_q    <= x_rep_d;
      src_x_q    <= src_x_d;
      y_rep_q    <= y_rep_d;
      src_y_q    <= src_y_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      pixel_q    <= pixel_d;
      valid_q    <= valid_d;
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
    end
  end

  assign addr_out   = addr_q;
  assign pixel_out  = pixel_q;
  assign valid_out  = valid_q;
  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;

endmodule

// File: tb/tb_scale_pipe.sv
// Bench for scale_pipe: directed raster sequences and randomized frames checked
// against a division-based model of the scaled window.
module tb_scale_pipe;

  localparam int SRC_W  = 240;
  localparam int SRC_H  = 320;
  localparam int PIX_W  = 16;
  localparam int RD_LAT = 2;
  localparam int LAT_C  = RD_LAT + 2;
  localparam int ADDR_W = $clog2(SRC_W * SRC_H);

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [1:0]        scale_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic [ADDR_W-1:0] addr_out;
  logic [PIX_W-1:0]  frame_buff_in;
  logic [PIX_W-1:0]  pixel_out;
  logic              valid_out;
  logic [10:0]       hcount_out;
  logic [9:0]        vcount_out;

  scale_pipe #(
    .SRC_W        (SRC_W),
    .SRC_H        (SRC_H),
    .PIX_W        (PIX_W),
    .RD_LAT       (RD_LAT),
    .BORDER_COLOR (16'hFFFF)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .scale_in      (scale_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .addr_out      (addr_out),
    .frame_buff_in (frame_buff_in),
    .pixel_out     (pixel_out),
    .valid_out     (valid_out),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out)
  );

  always #5 clk_in = ~clk_in;

  // Frame-buffer model: contents are a hash of the address.
  logic [ADDR_W-1:0] rd_sh [0:3];
  logic [15:0]       seed;

  function automatic logic [PIX_W-1:0] fb_word(input logic [ADDR_W-1:0] a, input logic [15:0] s);
    logic [31:0] t;
    t = ({15'd0, a} * 32'd40503) ^ {16'd0, s} ^ ({15'd0, a} >> 5);
    return t[PIX_W-1:0];
  endfunction

  always @(posedge clk_in) begin
    rd_sh[0] <= addr_out;
    for (int i = 1; i < 4; i++) rd_sh[i] <= rd_sh[i-1];
  end

  assign frame_buff_in = fb_word(rd_sh[RD_LAT-1], seed);

  // Reference model state: line/column counted since frame start.
  typedef struct {
    bit               rst;
    bit               win;
    int               addr;
    logic [PIX_W-1:0] pix;
    logic [10:0]      h;
    logic [9:0]       v;
  } ent_t;

  ent_t hist [16];
  int   cyc;
  int   n_assert;
  int   n_fail;
  int   m_line;
  int   m_col;
  int   m_scale;
  bit   m_est;

  task automatic check();
    ent_t             p;
    bit               z;
    logic [ADDR_W-1:0] ea;
    bit               ev;
    logic [PIX_W-1:0] ep;
    logic [10:0]      eh;
    logic [9:0]       evc;
    p  = hist[(cyc - 1) % 16];
    ea = p.rst ? '0 : ADDR_W'(p.addr);
    n_assert++;
    assert (addr_out === ea) else begin
      n_fail++;
      $error("FAIL addr cyc=%0d got=%0d want=%0d", cyc, addr_out, ea);
    end
    z = (cyc < LAT_C);
    for (int k = 1; k <= LAT_C; k++) begin
      if (cyc - k >= 0) begin
        if (hist[(cyc - k) % 16].rst) z = 1'b1;
      end
    end
    if (!z) p = hist[(cyc - LAT_C) % 16];
    ev  = z ? 1'b0 : p.win;
    ep  = (z || !p.win) ? '0 : p.pix;
    eh  = z ? 11'd0 : p.h;
    evc = z ? 10'd0 : p.v;
    n_assert++;
    assert (valid_out === ev) else begin
      n_fail++;
      $error("FAIL valid cyc=%0d got=%0b want=%0b", cyc, valid_out, ev);
    end
    n_assert++;
    assert (pixel_out === ep) else begin
      n_fail++;
      $error("FAIL pixel cyc=%0d got=%h want=%h", cyc, pixel_out, ep);
    end
    n_assert++;
    assert (hcount_out === eh) else begin
      n_fail++;
      $error("FAIL hcount cyc=%0d got=%0d want=%0d", cyc, hcount_out, eh);
    end
    n_assert++;
    assert (vcount_out === evc) else begin
      n_fail++;
      $error("FAIL vcount cyc=%0d got=%0d want=%0d", cyc, vcount_out, evc);
    end
  endtask

  // Drive one raster cycle, record its expectation, then check outputs after the edge.
  task automatic drive(input bit r, input int h, input int v);
    ent_t e;
    int   s;
    int   sx;
    int   sy;
    rst_in    = r;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    e.rst  = r;
    e.h    = 11'(h);
    e.v    = 10'(v);
    e.win  = 1'b0;
    e.addr = 0;
    e.pix  = '0;
    if (r) begin
      m_est   = 1'b0;
      m_scale = 0;
    end else begin
      if (h == 0 && v == 0) begin
        m_est   = 1'b1;
        m_scale = int'(scale_in);
        m_line  = 0;
        m_col   = 0;
      end else if (h == 0) begin
        m_line++;
        m_col = 0;
      end else begin
        m_col++;
      end
      s  = m_scale + 1;
      sx = m_col / s;
      sy = m_line / s;
      e.win = m_est && (sx < SRC_W) && (sy < SRC_H);
      if (e.win) begin
        e.addr = sy * SRC_W + sx;
        e.pix  = fb_word(ADDR_W'(e.addr), seed);
`ifdef SCALE_BORDER_EN
        if (sx == 0 || sx == SRC_W - 1 || sy == 0 || sy == SRC_H - 1) e.pix = 16'hFFFF;
`endif
      end
    end
    hist[cyc % 16] = e;
    @(posedge clk_in);
    cyc++;
    #1;
    check();
  endtask

  // vcount never returns to 0 inside a frame, even past 1023 lines.
  function automatic int vmap(input int l);
    return (l == 0) ? 0 : ((l - 1) % 1023) + 1;
  endfunction

  task automatic line(input int l, input int len);
    for (int h = 0; h < len; h++) drive(1'b0, h, vmap(l));
  endtask

  task automatic lines(input int l0, input int l1, input int len);
    for (int l = l0; l <= l1; l++) line(l, len);
  endtask

  initial begin
    int nl;
    int len;
    seed     = 16'($urandom);
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    m_line   = 0;
    m_col    = 0;
    m_scale  = 0;
    m_est    = 1'b0;
    scale_in = 2'd0;
    for (int i = 0; i < 5; i++) drive(1'b1, i, 5);

    // 1x: full first lines, fast lines to the bottom, last window line and the line below.
    scale_in = 2'd0;
    lines(0, 2, 256);
    lines(3, 318, 3);
    lines(319, 320, 256);

    // 2x: paired lines, bottom edge at line 639/640.
    scale_in = 2'd1;
    lines(0, 2, 500);
    lines(3, 638, 3);
    lines(639, 641, 500);

    // 4x: line 1279 is the last window line.
    scale_in = 2'd3;
    line(0, 980);
    lines(1, 1278, 2);
    lines(1279, 1280, 980);
    line(1281, 20);

    // Scale request changes mid-frame; takes effect at the next frame start.
    scale_in = 2'd0;
    lines(0, 99, 2);
    scale_in = 2'd2;
    line(100, 256);
    lines(101, 318, 2);
    lines(319, 320, 256);
    lines(0, 2, 730);
    lines(3, 958, 2);
    lines(959, 960, 730);

    // Three-cycle reset mid-line; stays dark until the next frame start.
    scale_in = 2'd1;
    lines(0, 4, 500);
    for (int h = 0; h < 100; h++) drive(1'b0, h, 5);
    for (int h = 100; h < 103; h++) drive(1'b1, h, 5);
    for (int h = 103; h < 500; h++) drive(1'b0, h, 5);
    lines(6, 8, 500);
    lines(0, 2, 500);

    // Randomized frames: scale, line lengths, mid-frame scale changes, sporadic resets.
    for (int f = 0; f < 6; f++) begin
      scale_in = 2'($urandom_range(0, 3));
      nl = int'($urandom_range(8, 40));
      for (int l = 0; l < nl; l++) begin
        len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 980)) : int'($urandom_range(1, 40));
        if (l > 0 && $urandom_range(0, 7) == 0) scale_in = 2'($urandom);
        for (int h = 0; h < len; h++) drive($urandom_range(0, 499) == 0, h, vmap(l));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
